// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage stallable delay line with per-stage valid bits,
// synchronous flush and a registered occupancy count.
module dff_pipe #(
  parameter int                WIDTH     = 8,
  parameter int                DEPTH     = 4,
  parameter bit                USE_EN    = 1'b1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             en_eff;

  assign en_eff = USE_EN ? en : 1'b1;

  // Flush beats advance; bubbles shift like data so latency stays fixed.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RESET_VAL;
      end
      valid_d = '0;
      count_d = '0;
    end else if (en_eff) begin
      data_d[0]  = d;
      valid_d[0] = d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      count_d = count_q + CW'(d_valid) - CW'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = valid_q[DEPTH-1];
  assign count   = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Randomised + directed bench for dff_pipe: queue-based reference model,
// scoreboard of in-flight valid samples, plus a DEPTH=1/USE_EN=0 instance.
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] RST_VAL = 8'h00;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             d_valid = 1'b0;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] c_d = '0;
  logic             c_dv = 1'b0;
  logic             c_flush = 1'b0;
  logic [WIDTH-1:0] c_q;
  logic             c_qv;
  logic [0:0]       c_count;

  int total = 0;
  int bad = 0;

  entry_t           mdl[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               last_adv = 1'b0;
  bit               chk_on = 1'b0;

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .USE_EN(1'b1), .RESET_VAL(RST_VAL)) u_dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q), .q_valid(q_valid), .count(count)
  );

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(1), .USE_EN(1'b0), .RESET_VAL(RST_VAL)) u_corner (
    .clk(clk), .rst(rst), .en(1'b0), .flush(c_flush), .d(c_d), .d_valid(c_dv),
    .q(c_q), .q_valid(c_qv), .count(c_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    mdl.delete();
    for (int i = 0; i < DEPTH; i++) mdl.push_back(entry_t'{v: 1'b0, data: RST_VAL});
    exp_q.delete();
  endfunction

  function automatic int model_count();
    int pc;
    pc = 0;
    foreach (mdl[i]) pc += int'(mdl[i].v);
    return pc;
  endfunction

  // Reference model: the pipe is a fixed-length queue, front = stage 0.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_clear();
      last_adv = 1'b0;
    end else if (flush) begin
      model_clear();
      last_adv = 1'b0;
    end else if (en) begin
      mdl.push_front(entry_t'{v: d_valid, data: d});
      void'(mdl.pop_back());
      if (d_valid) exp_q.push_back(d);
      last_adv = 1'b1;
    end else begin
      last_adv = 1'b0;
    end
  end

  // Monitor: compare registered outputs mid-cycle; pop scoreboard on each new valid output.
  always @(negedge clk) begin
    if (rst && chk_on) begin
      check_output("mdl_q", q, mdl[DEPTH-1].data);
      check_output("mdl_q_valid", q_valid, mdl[DEPTH-1].v);
      check_output("mdl_count", count, model_count());
      if (last_adv && q_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL sb_empty: got q=%0h with no sample pending", q);
        end else begin
          check_output("sb_data", q, exp_q.pop_front());
        end
      end
    end
  end

  task automatic apply_stimulus(input logic e, input logic f, input logic [WIDTH-1:0] dd, input logic dv);
    en = e;
    flush = f;
    d = dd;
    d_valid = dv;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] qv_seq;
    int         max_cnt;
    model_clear();
    rst = 1'b0;
    en = 1'b1;
    d = 8'hFF;
    d_valid = 1'b1;
    c_d = 8'h01;
    c_dv = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_output("rst_q", q, 8'h00);
      check_output("rst_q_valid", q_valid, 1'b0);
      check_output("rst_count", count, 0);
      check_output("rst_corner_q_valid", c_qv, 1'b0);
    end
    c_dv = 1'b0;
    d_valid = 1'b0;
    rst = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, $urandom, 1'b0);
    apply_stimulus(1'b1, 1'b0, $urandom, 1'b0);
    apply_stimulus(1'b1, 1'b0, $urandom, 1'b0);

    $display("[TB] streaming");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, WIDTH'(8'h11 * (i + 1)), 1'b1);
      check_output("stream_count", count, i + 1);
    end
    check_output("stream_q", q, 8'h11);
    check_output("stream_q_valid", q_valid, 1'b1);

    $display("[TB] stall");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'hAA, 1'b1);
      check_output("stall_q", q, 8'h11);
      check_output("stall_count", count, 4);
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, $urandom, 1'b0);
      if (i < 3) check_output("resume_q", q, WIDTH'(8'h11 * (i + 2)));
      check_output("resume_count", count, 3 - i);
      check_output("no_aa", (q_valid && q == 8'hAA), 1'b0);
    end

    $display("[TB] bubbles");
    max_cnt = 0;
    apply_stimulus(1'b1, 1'b0, 8'h01, 1'b1);
    if (int'(count) > max_cnt) max_cnt = int'(count);
    apply_stimulus(1'b1, 1'b0, $urandom, 1'b0);
    if (int'(count) > max_cnt) max_cnt = int'(count);
    apply_stimulus(1'b1, 1'b0, 8'h03, 1'b1);
    if (int'(count) > max_cnt) max_cnt = int'(count);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b1, 1'b0, $urandom, 1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (i < 3) qv_seq[2-i] = q_valid;
    end
    check_output("bubble_q_valid_seq", qv_seq, 3'b101);
    check_output("bubble_count_peak", max_cnt, 2);

    $display("[TB] flush");
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 1'b0, $urandom, 1'b1);
    check_output("prefill_count", count, DEPTH);
    apply_stimulus(1'b0, 1'b1, 8'h5A, 1'b1);
    check_output("flush_q", q, RST_VAL);
    check_output("flush_q_valid", q_valid, 1'b0);
    check_output("flush_count", count, 0);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b1, 1'b0, $urandom, 1'b0);
      check_output("flush_drop", q_valid, 1'b0);
    end

    $display("[TB] async reset");
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 1'b0, WIDTH'(8'hC0 + i), 1'b1);
    #2 rst = 1'b0;
    #1;
    check_output("async_q", q, 8'h00);
    check_output("async_q_valid", q_valid, 1'b0);
    check_output("async_count", count, 0);
    @(negedge clk);
    d_valid = 1'b0;
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 8'h77, 1'b1);
    check_output("post_rst_count", count, 1);
    for (int i = 0; i < DEPTH - 1; i++) apply_stimulus(1'b1, 1'b0, $urandom, 1'b0);
    check_output("post_rst_q", q, 8'h77);

    $display("[TB] random");
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(($urandom_range(9) < 7), ($urandom_range(19) == 0), $urandom, $urandom_range(1));
    end
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 1'b0, $urandom, 1'b0);
    check_output("drain_pending", exp_q.size(), 0);

    $display("[TB] depth1 corner");
    c_d = 8'h01;
    c_dv = 1'b1;
    @(negedge clk);
    check_output("corner_q", c_q, 8'h01);
    check_output("corner_q_valid", c_qv, 1'b1);
    check_output("corner_count1", c_count, 1'b1);
    c_dv = 1'b0;
    c_d = 8'h02;
    @(negedge clk);
    check_output("corner_count0", c_count, 1'b0);
    check_output("corner_q2", c_q, 8'h02);
    c_dv = 1'b1;
    @(negedge clk);
    check_output("corner_count_again", c_count, 1'b1);
    c_flush = 1'b1;
    @(negedge clk);
    check_output("corner_flush_q", c_q, RST_VAL);
    check_output("corner_flush_count", c_count, 1'b0);
    c_flush = 1'b0;

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised multi-stage register pipeline with per-stage valid tracking, a global stall enable, synchronous flush and an occupancy count. It generalises the single-bit enable flip-flop to a WIDTH-bit, DEPTH-stage delay line. It sits between datapath blocks that need a fixed, stallable latency, such as operand alignment or retiming across long routes.

## Interface
- WIDTH, default 8: data width in bits, at least 1.
- DEPTH, default 4: number of register stages, at least 1; this is the latency in enabled cycles.
- USE_EN, default 1: 1 means `en` gates all stage updates; 0 means `en` is ignored and treated as 1.
- RESET_VAL, default 0: WIDTH-bit value loaded into every data stage on reset and on flush.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; while it is low the pipeline holds (stall).
- flush  input  1  synchronous clear of all stages.
- d  input  WIDTH  data into stage 0.
- d_valid  input  1  qualifies `d`.
- q  output  WIDTH  data out of stage DEPTH-1.
- q_valid  output  1  valid bit of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of stages currently holding valid data.

## Operation
- Storage: DEPTH data registers data[0..DEPTH-1] and DEPTH valid bits v[0..DEPTH-1].
- Outputs: `q` = data[DEPTH-1] and `q_valid` = v[DEPTH-1], both registered with no combinational path from `d`.
- Reset (`rst`=0), applied asynchronously:
  - every data[i] = RESET_VAL and every v[i] = 0;
  - so `q` = RESET_VAL, `q_valid` = 0 and `count` = 0 while reset is held and after release.
- Priority at each rising edge, highest first: flush, then advance, then hold.
- flush=1:
  - all data[i] = RESET_VAL and all v[i] = 0;
  - the `d` and `d_valid` presented in that cycle are discarded;
  - this applies regardless of `en`.
- Advance (flush=0 and effective en=1):
  - data[0] <= d and v[0] <= d_valid;
  - data[i] <= data[i-1] and v[i] <= v[i-1] for i = 1..DEPTH-1;
  - the old stage DEPTH-1 contents are dropped.
  - Data is shifted even when d_valid=0, so bubbles propagate as entries with valid=0.
- Hold (flush=0 and effective en=0): all stages, `q`, `q_valid` and `count` keep their values.
- Effective en = `en` when USE_EN=1, and a constant 1 when USE_EN=0.
- count:
  - a registered population count of v[];
  - it is updated in the same edge as v[], with next count = count + v_in − v_out on advance;
  - it is 0 after flush and unchanged on hold;
  - it never exceeds DEPTH.
- DEPTH=1 degenerates to a single enable flip-flop with a valid bit, and `count` is 0 or 1.

## Timing
- Latency: a sample accepted at edge k, with en=1, appears on `q` after edge k+DEPTH−1 if en stays 1. That is DEPTH enabled edges from `d` to `q`.
- Stall cycles add latency one-for-one. No data or valid bit is lost or duplicated across a stall of any length.
- flush takes effect at the first edge where it is sampled high. From the following cycle, `q_valid`=0 and `count`=0.
- Flush while en=0 still clears.
- Flush and a valid `d` in the same cycle: `d` is dropped.
- Reset asserted mid-stream clears immediately without waiting for a clock edge. The first edge after release with en=1 loads stage 0 normally.
- Back-to-back valid inputs with en=1 sustain one output per cycle once the pipeline is full; `count` then stays at DEPTH.

## Test plan
- Reset behaviour, WIDTH=8, DEPTH=4:
  - stimulus: hold rst=0 for 2 cycles with d=8'hFF, d_valid=1, en=1;
  - required: q=8'h00, q_valid=0, count=0 throughout;
  - release reset, then assert rst=0 asynchronously mid-cycle while full;
  - required: outputs clear before the next edge.
- Streaming:
  - stimulus: en=1, d = 8'h11, 22, 33, 44, 55 with d_valid=1 on consecutive edges;
  - required: q=8'h11 with q_valid=1 after the 4th edge, then 22, 33, 44, 55 on the following cycles;
  - required: count rises 1, 2, 3, 4 and holds at 4.
- Stall:
  - stimulus: pipeline holds 11, 22, 33, 44; drop en for 3 cycles while d=8'hAA, d_valid=1;
  - required: q stays 8'h11, count stays 4, and 8'hAA is not captured;
  - on resume, q steps to 22, 33, 44.
- Bubbles:
  - stimulus: inputs valid, invalid, valid (8'h01, 8'hxx, 8'h03);
  - required: q_valid sequence 1, 0, 1 DEPTH cycles later;
  - required: count peaks at 2 and never exceeds DEPTH.
- Flush:
  - stimulus: full pipeline; assert flush=1 with en=0 and d_valid=1;
  - required: next cycle q=RESET_VAL, q_valid=0, count=0, and the flushed-cycle `d` never appears on `q`.
- Parameter corners:
  - stimulus: DEPTH=1, USE_EN=0 with en tied 0, d=1, d_valid=1;
  - required: q=1 after one edge, since en is ignored; count toggles between 0 and 1 with d_valid.
